// File: rtl/seq_detector_0010111_pkg.sv
// Shared definitions for the serial pattern detector.
//
// Holds the default pattern/length, the step classification used by the
// detector FSM, and the two constant functions that turn a pattern into
// KMP transition data at elaboration time:
//   kmp_next   - next matched-prefix length for (state, bit)
//   border_len - longest proper prefix of the pattern that is also a suffix
//
// Patterns are passed zero-extended to 16 bits; bit (len-1) of the pattern
// is the first bit to arrive on the serial line.
package seq_detector_0010111_pkg;

    localparam int         MAX_LEN         = 16;
    localparam int         DEFAULT_LEN     = 7;
    localparam logic [6:0] DEFAULT_PATTERN = 7'b0010111;

    // What one clock does to the matched-prefix state.
    typedef enum logic [1:0] {
        STEP_IDLE    = 2'd0,  // no accepted bit, state holds
        STEP_ADVANCE = 2'd1,  // bit matched the expected one, k -> k+1
        STEP_FAIL    = 2'd2,  // bit mismatched, take the failure transition
        STEP_MATCH   = 2'd3   // final pattern bit accepted
    } step_e;

    // Longest prefix of the pattern that is a suffix of
    // (first k pattern bits, followed by bit b). May return len.
    function automatic int kmp_next(int k, logic b, logic [15:0] pat, int len);
        int   res;
        int   j;
        logic ok;
        logic c;
        res = 0;
        for (int l = k + 1; l >= 1; l--) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                // Position of the i-th candidate-suffix bit within the
                // (k + 1)-bit string "prefix_k, b".
                j = k + 1 - l + i;
                c = (j < k) ? pat[4'(len - 1 - j)] : b;
                if (pat[4'(len - 1 - i)] != c) begin
                    ok = 1'b0;
                end
            end
            if (ok && (l > res)) begin
                res = l;
            end
        end
        return res;
    endfunction

    // Longest proper prefix that is also a suffix of the whole pattern.
    function automatic int border_len(logic [15:0] pat, int len);
        int   res;
        logic ok;
        res = 0;
        for (int l = 1; l < len; l++) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (pat[4'(len - 1 - i)] != pat[4'(l - 1 - i)]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                res = l;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_detector_0010111_sat_counter.sv
// Saturating up-counter with synchronous clear.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset (count -> 0)
//   inc   - add one on this edge unless already at the all-ones maximum
//   clr   - force count to zero on this edge; has priority over inc
//   count - current value
module seq_detector_0010111_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_0010111.sv
// Serial pattern detector (Moore style) with a saturating match counter.
//
// Watches a serial bit stream and pulses match for one cycle each time the
// programmed pattern has been received (MSB of PATTERN first).
//
// Ports:
//   clk         - rising-edge clock
//   rst         - asynchronous active-low reset
//   din         - serial data bit
//   din_valid   - din is consumed only when high
//   clr         - synchronous clear of match_count (FSM unaffected)
//   match       - registered one-cycle pulse after the final pattern bit
//   match_count - saturating number of matches since reset/clr
//   state       - matched-prefix length, for observation
//
// Handshake: din is accepted on a rising edge exactly when din_valid is high;
// there is no back-pressure, so every valid bit is consumed.
module seq_detector_0010111
    import seq_detector_0010111_pkg::*;
#(
    parameter int             LEN     = DEFAULT_LEN,
    parameter logic [LEN-1:0] PATTERN = DEFAULT_PATTERN,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din,
    input  logic                       din_valid,
    input  logic                       clr,
    output logic                       match,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(LEN+1)-1:0]   state
);

    localparam int            SW      = $clog2(LEN + 1);
    localparam int            TAB_N   = 2 ** (SW + 1);
    localparam logic [15:0]   PAT16   = 16'(PATTERN);
    localparam logic [SW-1:0] FULL    = SW'(LEN);
    // Where the FSM lands after a completed pattern.
    localparam logic [SW-1:0] RESTART = OVERLAP ? SW'(border_len(PAT16, LEN)) : '0;

    // Transition table indexed by {state, bit}, built entirely from
    // constants. Encodings at or above LEN cannot be reached; they are
    // steered back to 0 so a corrupted state recovers.
    logic [SW-1:0] nxt_tab [TAB_N];

    for (genvar g = 0; g < TAB_N; g++) begin : g_tab
        localparam int K = g / 2;
        if (K < LEN) begin : g_live
            assign nxt_tab[g] = SW'(kmp_next(K, 1'(g % 2), PAT16, LEN));
        end else begin : g_dead
            assign nxt_tab[g] = '0;
        end
    end

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          match_q;
    logic          match_d;
    logic [SW-1:0] cand;
    step_e         step;

    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        cand    = '0;
        step    = STEP_IDLE;

        // The lookup sits under din_valid so an undriven din while idle
        // never reaches the state register.
        if (din_valid) begin
            cand = nxt_tab[{state_q, din}];
            if (cand == FULL) begin
                step = STEP_MATCH;
            end else if (cand == (state_q + 1'b1)) begin
                step = STEP_ADVANCE;
            end else begin
                step = STEP_FAIL;
            end
        end

        case (step)
            STEP_ADVANCE, STEP_FAIL: begin
                state_d = cand;
            end
            STEP_MATCH: begin
                state_d = RESTART;
                match_d = 1'b1;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    // The count moves on the same edge that raises match, so the new value
    // is visible alongside the pulse.
    seq_detector_0010111_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match_d),
        .clr   (clr),
        .count (match_count)
    );

    assign match = match_q;
    assign state = state_q;

endmodule

// File: tb/tb_seq_detector_0010111.sv
// Bench for the serial pattern detector. Four detector instances share one
// input stream:
//   a: default 7-bit pattern 0010111, overlapping, 8-bit count
//   b: 4-bit pattern 1011, overlapping
//   c: 4-bit pattern 1011, non-overlapping
//   d: default pattern with a 2-bit count
// The reference model keeps the history of accepted bits and derives
// match/count/state directly from the pattern definition.
module tb_seq_detector_0010111;

    localparam int NM = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic clr = 1'b0;

    logic       m_a, m_b, m_c, m_d;
    logic [7:0] c_a, c_b, c_c;
    logic [1:0] c_d;
    logic [2:0] s_a, s_b, s_c, s_d;

    int pass_cnt = 0;
    int total_cnt = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    seq_detector_0010111 u_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
        .match(m_a), .match_count(c_a), .state(s_a)
    );

    seq_detector_0010111 #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) u_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
        .match(m_b), .match_count(c_b), .state(s_b)
    );

    seq_detector_0010111 #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) u_c (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
        .match(m_c), .match_count(c_c), .state(s_c)
    );

    seq_detector_0010111 #(.CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
        .match(m_d), .match_count(c_d), .state(s_d)
    );

    // ---------------- reference model ----------------
    int          m_len  [NM] = '{7, 4, 4, 7};
    logic [15:0] m_pat  [NM] = '{16'h0017, 16'h000B, 16'h000B, 16'h0017};
    bit          m_ovl  [NM] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int          m_cmax [NM] = '{255, 255, 255, 3};
    logic [63:0] m_hist [NM] = '{64'd0, 64'd0, 64'd0, 64'd0};
    int          m_nh   [NM] = '{0, 0, 0, 0};
    int          e_match[NM] = '{0, 0, 0, 0};
    int          e_count[NM] = '{0, 0, 0, 0};
    int          e_state[NM] = '{0, 0, 0, 0};

    // Do the last k accepted bits (newest in bit 0) equal the first k
    // pattern bits?
    function automatic bit tail_is_prefix(logic [63:0] h, int nh, logic [15:0] pat,
                                          int len, int k);
        logic [63:0] mask;
        logic [63:0] want;
        if (k > nh) return 1'b0;
        mask = (64'd1 << k) - 64'd1;
        want = {48'd0, pat} >> (len - k);
        return (h & mask) == want;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NM; i++) begin
            m_hist[i]  = 64'd0;
            m_nh[i]    = 0;
            e_match[i] = 0;
            e_count[i] = 0;
            e_state[i] = 0;
        end
    endtask

    // Expected outputs after the next rising edge with these inputs.
    task automatic model_step(logic b, logic v, logic c);
        for (int i = 0; i < NM; i++) begin
            e_match[i] = 0;
            if (v) begin
                m_hist[i] = {m_hist[i][62:0], b};
                if (m_nh[i] < 64) m_nh[i] = m_nh[i] + 1;
                if (tail_is_prefix(m_hist[i], m_nh[i], m_pat[i], m_len[i], m_len[i])) begin
                    e_match[i] = 1;
                    if (e_count[i] < m_cmax[i]) e_count[i] = e_count[i] + 1;
                    if (!m_ovl[i]) m_nh[i] = 0;
                end
            end
            if (c) e_count[i] = 0;
            e_state[i] = 0;
            for (int k = m_len[i] - 1; k >= 1; k--) begin
                if (e_state[i] == 0 &&
                    tail_is_prefix(m_hist[i], m_nh[i], m_pat[i], m_len[i], k)) begin
                    e_state[i] = k;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a_match", 32'(m_a), e_match[0]);
        check("a_count", 32'(c_a), e_count[0]);
        check("a_state", 32'(s_a), e_state[0]);
        check("b_match", 32'(m_b), e_match[1]);
        check("b_count", 32'(c_b), e_count[1]);
        check("b_state", 32'(s_b), e_state[1]);
        check("c_match", 32'(m_c), e_match[2]);
        check("c_count", 32'(c_c), e_count[2]);
        check("c_state", 32'(s_c), e_state[2]);
        check("d_match", 32'(m_d), e_match[3]);
        check("d_count", 32'(c_d), e_count[3]);
        check("d_state", 32'(s_d), e_state[3]);
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge: drive, let one rising edge pass,
    // then compare at the following falling edge.
    task automatic send(logic b, logic v, logic c);
        model_step(b, v, c);
        din       = b;
        din_valid = v;
        clr       = c;
        @(negedge clk);
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    logic [6:0] bits7;
    logic [7:0] bits8;
    logic [6:0] bits_b;
    int         seq_a [7] = '{1, 2, 3, 4, 5, 6, 0};
    int         sat_d [5] = '{1, 2, 3, 3, 0};

    initial begin
        bits7  = 7'b0010111;
        bits8  = 8'b00010111;
        bits_b = 7'b1011011;

        // Reset
        repeat (3) @(negedge clk);
        compare_all();
        check("reset_state", 32'(s_a), 32'd0);
        check("reset_match", 32'(m_a), 32'd0);
        check("reset_count", 32'(c_a), 32'd0);
        rst = 1'b1;

        // Plain pattern: state walks 1..6 then back to 0 with a match
        for (int i = 0; i < 7; i++) begin
            send(bits7[6-i], 1'b1, 1'b0);
            check("p1_state_seq", 32'(s_a), seq_a[i]);
            if (i == 5) check("p1_no_early_match", 32'(m_a), 32'd0);
        end
        check("p1_match", 32'(m_a), 32'd1);
        check("p1_count", 32'(c_a), 32'd1);
        send(1'b0, 1'b0, 1'b1);
        check("p1_pulse_one_cycle", 32'(m_a), 32'd0);

        // Extra leading zero exercises the failure transition 2 -> 2
        for (int i = 0; i < 8; i++) begin
            send(bits8[7-i], 1'b1, 1'b0);
            if (i == 2) check("p2_fail_holds_2", 32'(s_a), 32'd2);
            if (i == 6) check("p2_no_early_match", 32'(m_a), 32'd0);
        end
        check("p2_match", 32'(m_a), 32'd1);
        check("p2_count", 32'(c_a), 32'd1);
        send(1'b0, 1'b0, 1'b1);

        // 1011 with and without overlap on stream 1011011
        for (int i = 0; i < 7; i++) begin
            send(bits_b[6-i], 1'b1, 1'b0);
            if (i == 3) begin
                check("p3_b_match4", 32'(m_b), 32'd1);
                check("p3_c_match4", 32'(m_c), 32'd1);
            end
            if (i == 4) check("p3_b_gap", 32'(m_b), 32'd0);
        end
        check("p3_b_match7", 32'(m_b), 32'd1);
        check("p3_c_no_match7", 32'(m_c), 32'd0);
        check("p3_b_count", 32'(c_b), 32'd2);
        check("p3_c_count", 32'(c_c), 32'd1);
        send(1'b0, 1'b0, 1'b1);

        // Valid gap of three cycles after bit 4, din undriven while idle
        for (int i = 0; i < 4; i++) send(bits7[6-i], 1'b1, 1'b0);
        check("p4_state4", 32'(s_a), 32'd4);
        for (int i = 0; i < 3; i++) begin
            send(1'bx, 1'b0, 1'b0);
            check("p4_gap_state", 32'(s_a), 32'd4);
            check("p4_gap_match", 32'(m_a), 32'd0);
        end
        for (int i = 4; i < 7; i++) send(bits7[6-i], 1'b1, 1'b0);
        check("p4_match", 32'(m_a), 32'd1);
        check("p4_count", 32'(c_a), 32'd1);

        // Asynchronous reset between edges while at state 5
        for (int i = 0; i < 5; i++) send(bits7[6-i], 1'b1, 1'b0);
        check("p6_state5", 32'(s_a), 32'd5);
        din_valid = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("p6_async_state", 32'(s_a), 32'd0);
        check("p6_async_match", 32'(m_a), 32'd0);
        check("p6_async_count", 32'(c_a), 32'd0);
        @(negedge clk);
        compare_all();
        rst = 1'b1;
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        check("p6_tail_no_match", 32'(m_a), 32'd0);
        for (int i = 0; i < 7; i++) send(bits7[6-i], 1'b1, 1'b0);
        check("p6_full_match", 32'(m_a), 32'd1);
        check("p6_full_count", 32'(c_a), 32'd1);
        send(1'b0, 1'b0, 1'b1);

        // 2-bit counter saturation, clr on the edge of the 5th match
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 7; i++) send(bits7[6-i], 1'b1, (p == 4) && (i == 6));
            check("p5_sat_count", 32'(c_d), sat_d[p]);
            check("p5_match", 32'(m_d), 32'd1);
        end
        send(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
